word_byte_writer: RTL and testbench

WORD_BYTE_WRITER -- requirements
Module: word_byte_writer

---
 rtl/word_byte_writer.sv | 93 +++++++++
 tb/tb_word_byte_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_writer.sv
// Splits 16-bit store requests into two consecutive byte writes to an 8-bit memory.
// Byte order is selected by LO_FIRST; the second byte goes to base+1, wrapping at 2^ADDR_W.
module word_byte_writer #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned LO_FIRST = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [15:0]       InData,
    input  logic [ADDR_W-1:0] InAddr,
    input  logic              MemBusy,
    output logic              MemWr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemData,
    output logic              MemLH,
    output logic              Done,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } state_t;

    localparam logic LO = (LO_FIRST != 0);

    state_t            state;
    state_t            state_next;
    logic [15:0]       hold_data;
    logic [ADDR_W-1:0] hold_addr;
    logic              accept;
    logic              done_q;

    assign accept = InValid & InReady;
    assign Done   = done_q;
    assign Busy   = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == SECOND) && !MemBusy;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_data <= '0;
            hold_addr <= '0;
        end else if (accept) begin
            hold_data <= InData;
            hold_addr <= InAddr;
        end
    end

    // SECOND accepts the next word on its completion edge so streams run gap-free.
    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        MemWr      = 1'b0;
        MemAddr    = '0;
        MemData    = '0;
        MemLH      = 1'b0;
        case (state)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) state_next = FIRST;
            end
            FIRST: begin
                MemWr   = 1'b1;
                MemAddr = hold_addr;
                MemData = LO ? hold_data[7:0] : hold_data[15:8];
                MemLH   = ~LO;
                if (!MemBusy) state_next = SECOND;
            end
            SECOND: begin
                MemWr   = 1'b1;
                MemAddr = hold_addr + ADDR_W'(1);
                MemData = LO ? hold_data[15:8] : hold_data[7:0];
                MemLH   = LO;
                InReady = ~MemBusy;
                if (!MemBusy) state_next = InValid ? FIRST : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_word_byte_writer.sv
// Directed bench for word_byte_writer: one low-first and one high-first instance share stimulus.
// Inputs change and outputs are checked on the falling clock edge.
module tb_word_byte_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] in_addr;
    logic        mem_busy;

    logic        rdy_lo, wr_lo, lh_lo, done_lo, busy_lo;
    logic [15:0] addr_lo;
    logic [7:0]  data_lo;
    logic        rdy_hi, wr_hi, lh_hi, done_hi, busy_hi;
    logic [15:0] addr_hi;
    logic [7:0]  data_hi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    word_byte_writer #(.ADDR_W(16), .LO_FIRST(1)) u_lo (
        .Clock(clock), .Reset(reset), .InValid(in_valid), .InReady(rdy_lo),
        .InData(in_data), .InAddr(in_addr), .MemBusy(mem_busy), .MemWr(wr_lo),
        .MemAddr(addr_lo), .MemData(data_lo), .MemLH(lh_lo), .Done(done_lo), .Busy(busy_lo)
    );

    word_byte_writer #(.ADDR_W(16), .LO_FIRST(0)) u_hi (
        .Clock(clock), .Reset(reset), .InValid(in_valid), .InReady(rdy_hi),
        .InData(in_data), .InAddr(in_addr), .MemBusy(mem_busy), .MemWr(wr_hi),
        .MemAddr(addr_hi), .MemData(data_hi), .MemLH(lh_hi), .Done(done_hi), .Busy(busy_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic chk_lo(input string tag, input logic [15:0] a, input logic [7:0] d, input logic lh);
        check({tag, ".wr"},   32'(wr_lo),   32'd1);
        check({tag, ".addr"}, 32'(addr_lo), 32'(a));
        check({tag, ".data"}, 32'(data_lo), 32'(d));
        check({tag, ".lh"},   32'(lh_lo),   32'(lh));
    endtask

    task automatic chk_hi(input string tag, input logic [15:0] a, input logic [7:0] d, input logic lh);
        check({tag, ".wr"},   32'(wr_hi),   32'd1);
        check({tag, ".addr"}, 32'(addr_hi), 32'(a));
        check({tag, ".data"}, 32'(data_hi), 32'(d));
        check({tag, ".lh"},   32'(lh_hi),   32'(lh));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".wr"},    32'(wr_lo),   32'd0);
        check({tag, ".busy"},  32'(busy_lo), 32'd0);
        check({tag, ".rdy"},   32'(rdy_lo),  32'd1);
        check({tag, ".addr"},  32'(addr_lo), 32'd0);
        check({tag, ".data"},  32'(data_lo), 32'd0);
        check({tag, ".lh"},    32'(lh_lo),   32'd0);
    endtask

    task automatic request(input logic [15:0] d, input logic [15:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_addr  = '0;
        mem_busy = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_idle("rst");
        check("rst.done", 32'(done_lo), 32'd0);
        check("rst.hi_busy", 32'(busy_hi), 32'd0);

        // Single store, with input changes after acceptance that must not leak through
        request(16'hA55A, 16'h0040);
        cyc();
        chk_lo("s1.b0", 16'h0040, 8'h5A, 1'b0);
        chk_hi("s1h.b0", 16'h0040, 8'hA5, 1'b1);
        check("s1.rdy0", 32'(rdy_lo), 32'd0);
        check("s1.busy", 32'(busy_lo), 32'd1);
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        in_addr  = 16'h1234;
        cyc();
        chk_lo("s1.b1", 16'h0041, 8'hA5, 1'b1);
        chk_hi("s1h.b1", 16'h0041, 8'h5A, 1'b0);
        check("s1.rdy1", 32'(rdy_lo), 32'd1);
        check("s1.nodone", 32'(done_lo), 32'd0);
        cyc();
        check("s1.done", 32'(done_lo), 32'd1);
        check("s1h.done", 32'(done_hi), 32'd1);
        chk_idle("s1.idle");
        cyc();
        check("s1.done_off", 32'(done_lo), 32'd0);

        // Stall three cycles during the first byte
        request(16'hA55A, 16'h0040);
        cyc();
        chk_lo("st.b0", 16'h0040, 8'h5A, 1'b0);
        in_valid = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_lo("st.hold", 16'h0040, 8'h5A, 1'b0);
            check("st.rdy", 32'(rdy_lo), 32'd0);
            check("st.nodone", 32'(done_lo), 32'd0);
        end
        mem_busy = 1'b0;
        cyc();
        chk_lo("st.b1", 16'h0041, 8'hA5, 1'b1);
        cyc();
        check("st.done", 32'(done_lo), 32'd1);
        check("st.idle", 32'(busy_lo), 32'd0);
        cyc();

        // Back-to-back words with InValid held
        request(16'h1122, 16'h0010);
        cyc();
        chk_lo("bb.w0b0", 16'h0010, 8'h22, 1'b0);
        request(16'h3344, 16'h0020);
        cyc();
        chk_lo("bb.w0b1", 16'h0011, 8'h11, 1'b1);
        check("bb.rdy", 32'(rdy_lo), 32'd1);
        cyc();
        chk_lo("bb.w1b0", 16'h0020, 8'h44, 1'b0);
        check("bb.done0", 32'(done_lo), 32'd1);
        in_valid = 1'b0;
        cyc();
        chk_lo("bb.w1b1", 16'h0021, 8'h33, 1'b1);
        check("bb.gap", 32'(done_lo), 32'd0);
        cyc();
        check("bb.done1", 32'(done_lo), 32'd1);
        check("bb.idle", 32'(wr_lo), 32'd0);
        cyc();
        check("bb.done_off", 32'(done_lo), 32'd0);

        // Address wrap on the second byte
        request(16'hBEEF, 16'hFFFF);
        cyc();
        in_valid = 1'b0;
        chk_lo("wr.b0", 16'hFFFF, 8'hEF, 1'b0);
        chk_hi("wrh.b0", 16'hFFFF, 8'hBE, 1'b1);
        cyc();
        chk_lo("wr.b1", 16'h0000, 8'hBE, 1'b1);
        chk_hi("wrh.b1", 16'h0000, 8'hEF, 1'b0);
        cyc();
        cyc();

        // High-byte-first order
        request(16'hBEEF, 16'h0100);
        cyc();
        in_valid = 1'b0;
        chk_hi("hf.b0", 16'h0100, 8'hBE, 1'b1);
        cyc();
        chk_hi("hf.b1", 16'h0101, 8'hEF, 1'b0);
        cyc();
        check("hf.done", 32'(done_hi), 32'd1);
        cyc();

        // Reset dominates a simultaneous request
        reset = 1'b1;
        request(16'h7777, 16'h0777);
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_idle("rd");
        cyc();
        check("rd.still_idle", 32'(busy_lo), 32'd0);

        // Reset while the second byte is on the bus
        request(16'h1234, 16'h0200);
        cyc();
        in_valid = 1'b0;
        chk_lo("rs.b0", 16'h0200, 8'h34, 1'b0);
        cyc();
        chk_lo("rs.b1", 16'h0201, 8'h12, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_idle("rs.after");
        check("rs.nodone", 32'(done_lo), 32'd0);
        cyc();
        check("rs.nodone2", 32'(done_lo), 32'd0);
        request(16'h5678, 16'h0300);
        cyc();
        in_valid = 1'b0;
        chk_lo("rs.n0", 16'h0300, 8'h78, 1'b0);
        cyc();
        chk_lo("rs.n1", 16'h0301, 8'h56, 1'b1);
        cyc();
        check("rs.ndone", 32'(done_lo), 32'd1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
